niveles_canales: RTL

//   Generalised need-level tracker for the Tamagotchi core: N_CH independent levels (hunger, fun, energy, ...).

---
 rtl/niveles_canales.sv | 115 +++++++++++
 1 files changed

// File: rtl/niveles_canales.sv
// Need-level tracker: N_CH saturating levels driven by debounced care buttons and a shared decay tick.
// Optional NIVELES_ACEL_EN adds a 'test' port that shortens the decay period by ACCEL.
module niveles_canales #(
  parameter int unsigned     N_CH      = 4,
  parameter int unsigned     LVL_W     = 3,
  parameter int unsigned     LVL_MIN   = 1,
  parameter int unsigned     LVL_MAX   = 5,
  parameter logic [N_CH-1:0] DIR       = N_CH'(4'b0101),
  parameter int unsigned     CLK_FREQ  = 50000000,
  parameter int unsigned     PERIODO_S = 25,
  parameter int unsigned     DB_LEN    = 3,
  parameter int unsigned     CRIT_N    = 2,
  parameter int unsigned     ACCEL     = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       btn_n,
  input  logic                  pausa,
`ifdef NIVELES_ACEL_EN
  input  logic                  test,
`endif
  output logic [N_CH*LVL_W-1:0] niveles,
  output logic [N_CH-1:0]       alerta,
  output logic                  tick,
  output logic                  critico
);

  localparam int unsigned   CNT_W   = 32;
  localparam logic [CNT_W-1:0] TC_FULL = CNT_W'(CLK_FREQ * PERIODO_S - 1);
  localparam logic [CNT_W-1:0] TC_FAST = CNT_W'((CLK_FREQ * PERIODO_S) / ACCEL - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_test;
  logic [CNT_W-1:0] w_tc;

`ifdef NIVELES_ACEL_EN
  assign w_test = test;
`else
  assign w_test = 1'b0;
`endif

  assign w_tc = w_test ? TC_FAST : TC_FULL;

  // Decay prescaler; '>=' lets a shortened TC wrap a counter already past it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (pausa) begin
      r_tick <= 1'b0;
    end else if (r_cnt >= w_tc) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    localparam logic [LVL_W-1:0] LV_HI  = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0] LV_LO  = LVL_W'(LVL_MIN);
    localparam logic [LVL_W-1:0] LV_BAD = DIR[g] ? LV_HI : LV_LO;
    localparam logic [LVL_W-1:0] LV_RST = DIR[g] ? LV_LO : LV_HI;

    logic [DB_LEN-1:0] r_sh;
    logic              r_rel;
    logic [LVL_W-1:0]  r_lvl;
    logic              r_alr;
    logic              w_low, w_high, w_press, w_up, w_dn;
    logic [LVL_W-1:0]  w_nxt;

    assign w_low   = ~|r_sh;
    assign w_high  = &r_sh;
    assign w_press = w_low & r_rel;
    assign w_up    = DIR[g] ? r_tick  : w_press;
    assign w_dn    = DIR[g] ? w_press : r_tick;

    // Simultaneous up/down requests cancel.
    always_comb begin
      w_nxt = r_lvl;
      if (w_up && !w_dn && (r_lvl < LV_HI)) begin
        w_nxt = r_lvl + LVL_W'(1);
      end else if (w_dn && !w_up && (r_lvl > LV_LO)) begin
        w_nxt = r_lvl - LVL_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_sh  <= '1;
        r_rel <= 1'b1;
        r_lvl <= LV_RST;
        r_alr <= 1'b0;
      end else begin
        r_sh <= {r_sh[DB_LEN-2:0], btn_n[g]};
        if (w_low) begin
          r_rel <= 1'b0;
        end else if (w_high) begin
          r_rel <= 1'b1;
        end
        r_lvl <= w_nxt;
        r_alr <= (w_nxt == LV_BAD);
      end
    end

    assign niveles[g*LVL_W +: LVL_W] = r_lvl;
    assign alerta[g]                 = r_alr;
  end

  assign tick    = r_tick;
  assign critico = ($countones(alerta) >= CRIT_N);

endmodule
